// File: rtl/task_dispatcher_if.sv
// ---------------------------------------------------------------------------
// task_dispatcher_if
//   Bundles the signals between the task dispatcher and its environment:
//   the task submission handshake, the three engine start/cfg/irq triplets
//   (pb0, pb1, pp), the completion report and the status outputs.
//
//   Modports
//     slave  : the dispatcher side (accepts tasks, drives engines, reports).
//     master : the environment side (offers tasks, answers with irqs).
//
//   Signals
//     task_valid/task_ready/task_type/task_cfg : task submission handshake
//     pbX_start/pbX_cfg/pbX_irq, pp_*          : per-engine control
//     done_valid/done_eng                      : completion report
//     cont_busy, err_irq                       : controller status
// ---------------------------------------------------------------------------
interface task_dispatcher_if #(
    parameter int CFG_W = 96
) ();

    logic             task_valid;
    logic             task_ready;
    logic             task_type;
    logic [CFG_W-1:0] task_cfg;

    logic             pb0_start;
    logic [CFG_W-1:0] pb0_cfg;
    logic             pb0_irq;

    logic             pb1_start;
    logic [CFG_W-1:0] pb1_cfg;
    logic             pb1_irq;

    logic             pp_start;
    logic [CFG_W-1:0] pp_cfg;
    logic             pp_irq;

    logic             done_valid;
    logic [1:0]       done_eng;
    logic             cont_busy;
    logic             err_irq;

    modport slave (
        input  task_valid, task_type, task_cfg,
        input  pb0_irq, pb1_irq, pp_irq,
        output task_ready,
        output pb0_start, pb0_cfg, pb1_start, pb1_cfg, pp_start, pp_cfg,
        output done_valid, done_eng, cont_busy, err_irq
    );

    modport master (
        output task_valid, task_type, task_cfg,
        output pb0_irq, pb1_irq, pp_irq,
        input  task_ready,
        input  pb0_start, pb0_cfg, pb1_start, pb1_cfg, pp_start, pp_cfg,
        input  done_valid, done_eng, cont_busy, err_irq
    );

endinterface

// File: rtl/task_dispatcher.sv
// ---------------------------------------------------------------------------
// task_dispatcher
//   Sits in front of two packet builders (pb0, pb1) and one packet parser
//   (pp). Tasks are queued in a small FIFO and dispatched strictly in order:
//   parse tasks go to pp, build tasks to whichever builder is free
//   (alternating when both are free). Each engine has an IDLE->START->WAIT
//   FSM that issues a one-cycle start pulse and holds the task config until
//   the engine's irq. Completions are reported one per cycle, pb0 > pb1 > pp,
//   with losers parked in per-engine pending bits.
//
//   Ports
//     clk    : clock, all logic on the rising edge
//     reset  : asynchronous, active-low reset
//     bus    : task_dispatcher_if.slave (task handshake, engine control,
//              completion report, cont_busy / err_irq status)
// ---------------------------------------------------------------------------
module task_dispatcher #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CFG_W       = 96
) (
    input  logic                 clk,
    input  logic                 reset,
    task_dispatcher_if.slave     bus
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int NUM_ENG = 3;            // 0 = pb0, 1 = pb1, 2 = pp

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_START = 2'd1,
        ENG_WAIT  = 2'd2
    } eng_state_e;

    typedef struct packed {
        logic             task_type;       // 0 = build, 1 = parse
        logic [CFG_W-1:0] cfg;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    entry_t           fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ready_en_q, ready_en_d;   // keeps task_ready low until the first edge after reset

    eng_state_e       state_q [NUM_ENG];
    eng_state_e       state_d [NUM_ENG];
    logic [CFG_W-1:0] cfg_q   [NUM_ENG];
    logic [CFG_W-1:0] cfg_d   [NUM_ENG];
    logic             last_pb_q, last_pb_d;     // builder that took the previous build task

    logic [NUM_ENG-1:0] pending_q, pending_d;
    logic               done_valid_q, done_valid_d;
    logic [1:0]         done_eng_q,   done_eng_d;
    logic               err_irq_q,    err_irq_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    entry_t             head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               dispatch;
    logic [1:0]         disp_eng;
    logic [NUM_ENG-1:0] eng_idle;
    logic [NUM_ENG-1:0] eng_wait;
    logic [NUM_ENG-1:0] irq_vec;
    logic [NUM_ENG-1:0] irq_ok;
    logic [NUM_ENG-1:0] done_req;
    logic [NUM_ENG-1:0] done_grant;

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign push       = bus.task_valid && bus.task_ready;
    assign irq_vec    = {bus.pp_irq, bus.pb1_irq, bus.pb0_irq};

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_idle[i] = (state_q[i] == ENG_IDLE);
            eng_wait[i] = (state_q[i] == ENG_WAIT);
        end
    end

    // Only an irq from an engine that is waiting for one completes a task.
    assign irq_ok = irq_vec & eng_wait;

    // -----------------------------------------------------------------------
    // Dispatch decision: only the FIFO head is ever considered, so a blocked
    // build task also holds back any parse task queued behind it.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        dispatch = 1'b0;
        disp_eng = 2'd0;
        if (!fifo_empty) begin
            if (head.task_type) begin
                if (eng_idle[2]) begin
                    dispatch = 1'b1;
                    disp_eng = 2'd2;
                end
            end else if (eng_idle[0] && eng_idle[1]) begin
                dispatch = 1'b1;
                disp_eng = last_pb_q ? 2'd0 : 2'd1;
            end else if (eng_idle[0]) begin
                dispatch = 1'b1;
                disp_eng = 2'd0;
            end else if (eng_idle[1]) begin
                dispatch = 1'b1;
                disp_eng = 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping (pop happens only on dispatch)
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready_en_d = 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;     // power-of-two depth wraps naturally
        end
        if (dispatch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, dispatch})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the task storage has no reset; validity is tracked entirely by
    // the pointers and count, so clearing the data array would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{task_type: bus.task_type, cfg: bus.task_cfg};
        end
    end

    // -----------------------------------------------------------------------
    // Per-engine FSMs and config registers
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        last_pb_d = last_pb_q;
        for (int i = 0; i < NUM_ENG; i++) begin
            case (state_q[i])
                ENG_IDLE: begin
                    if (dispatch && (disp_eng == 2'(i))) begin
                        state_d[i] = ENG_START;
                        cfg_d[i]   = head.cfg;
                    end
                end
                ENG_START: state_d[i] = ENG_WAIT;
                ENG_WAIT: begin
                    if (irq_vec[i]) begin
                        state_d[i] = ENG_IDLE;
                    end
                end
                default: state_d[i] = ENG_IDLE;
            endcase
        end
        if (dispatch && !head.task_type) begin
            last_pb_d = disp_eng[0];
        end
    end

    // -----------------------------------------------------------------------
    // Completion reporting: fixed priority pb0 > pb1 > pp over fresh irqs and
    // previously parked ones; whatever is not granted stays pending.
    // -----------------------------------------------------------------------
    always_comb begin
        done_req     = pending_q | irq_ok;
        done_grant   = '0;
        done_valid_d = 1'b0;
        done_eng_d   = 2'd0;
        if (done_req[0]) begin
            done_grant   = 3'b001;
            done_valid_d = 1'b1;
            done_eng_d   = 2'd0;
        end else if (done_req[1]) begin
            done_grant   = 3'b010;
            done_valid_d = 1'b1;
            done_eng_d   = 2'd1;
        end else if (done_req[2]) begin
            done_grant   = 3'b100;
            done_valid_d = 1'b1;
            done_eng_d   = 2'd2;
        end
        pending_d = done_req & ~done_grant;
        // An irq from an engine that is not waiting is a protocol error.
        err_irq_d = err_irq_q | (|(irq_vec & ~eng_wait));
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_en_q   <= 1'b0;
            for (int i = 0; i < NUM_ENG; i++) begin
                state_q[i] <= ENG_IDLE;
                cfg_q[i]   <= '0;
            end
            last_pb_q    <= 1'b1;           // first build after reset goes to pb0
            pending_q    <= '0;
            done_valid_q <= 1'b0;
            done_eng_q   <= 2'd0;
            err_irq_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its _d value from before this edge.
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_en_q   <= ready_en_d;
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            last_pb_q    <= last_pb_d;
            pending_q    <= pending_d;
            done_valid_q <= done_valid_d;
            done_eng_q   <= done_eng_d;
            err_irq_q    <= err_irq_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.task_ready = ready_en_q && !fifo_full;

    assign bus.pb0_start  = (state_q[0] == ENG_START);
    assign bus.pb1_start  = (state_q[1] == ENG_START);
    assign bus.pp_start   = (state_q[2] == ENG_START);
    assign bus.pb0_cfg    = cfg_q[0];
    assign bus.pb1_cfg    = cfg_q[1];
    assign bus.pp_cfg     = cfg_q[2];

    assign bus.done_valid = done_valid_q;
    assign bus.done_eng   = done_eng_q;
    assign bus.err_irq    = err_irq_q;

    // Busy until the last completion has actually been reported.
    assign bus.cont_busy  = !fifo_empty || !(&eng_idle) || (|pending_q) || done_valid_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_task_dispatcher
//   Directed bench for task_dispatcher. Inputs change 1 time unit after a
//   rising edge; outputs are checked at the same point, i.e. they show the
//   state loaded by the edge just passed.
// ---------------------------------------------------------------------------
module tb_task_dispatcher;

    localparam int CFG_W = 96;

    localparam logic [CFG_W-1:0] CFG_A = 96'hA0A0_0001_1111_2222_3333_4444;
    localparam logic [CFG_W-1:0] CFG_B = 96'hB0B0_0002_5555_6666_7777_8888;
    localparam logic [CFG_W-1:0] CFG_C = 96'hC0C0_0003_9999_AAAA_BBBB_CCCC;
    localparam logic [CFG_W-1:0] CFG_D = 96'hD0D0_0004_DDDD_EEEE_FFFF_0000;
    localparam logic [CFG_W-1:0] CFG_E = 96'hE0E0_0005_1234_5678_9ABC_DEF0;
    localparam logic [CFG_W-1:0] CFG_F = 96'hF0F0_0006_0F0F_F0F0_A5A5_5A5A;
    localparam logic [CFG_W-1:0] CFG_G = 96'h1717_0007_2468_ACE0_1357_9BDF;
    localparam logic [CFG_W-1:0] CFG_H = 96'h2828_0008_FEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    task_dispatcher_if #(.CFG_W(CFG_W)) bus ();

    task_dispatcher #(
        .QUEUE_DEPTH (4),
        .CFG_W       (CFG_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_task(input logic valid, input logic ttype, input logic [CFG_W-1:0] cfg);
        bus.task_valid = valid;
        bus.task_type  = ttype;
        bus.task_cfg   = cfg;
    endtask

    task automatic drive_irq(input logic i0, input logic i1, input logic i2);
        bus.pb0_irq = i0;
        bus.pb1_irq = i1;
        bus.pp_irq  = i2;
    endtask

    task automatic do_reset();
        drive_task(1'b0, 1'b0, '0);
        drive_irq(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    // Reset state, and task_ready rising only one cycle after release.
    task automatic test_reset();
        drive_task(1'b0, 1'b0, '0);
        drive_irq(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        n_checks++; if ({bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start, bus.done_valid, bus.done_eng, bus.cont_busy, bus.err_irq} !== 9'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 0", {bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start, bus.done_valid, bus.done_eng, bus.cont_busy, bus.err_irq}); end
        n_checks++; if ({bus.pb0_cfg, bus.pb1_cfg, bus.pp_cfg} !== '0)
            begin n_fail++; $display("FAIL reset_cfg: got %h want 0", {bus.pb0_cfg, bus.pb1_cfg, bus.pp_cfg}); end
        @(posedge clk);
        #1 reset = 1'b1;
        n_checks++; if (bus.task_ready !== 1'b0)
            begin n_fail++; $display("FAIL reset_ready_at_release: got %b want 0", bus.task_ready); end
        tick();
        n_checks++; if (bus.task_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", bus.task_ready); end
    endtask

    // Single build on an idle system: start two edges after accept, done
    // the edge after irq, busy low one cycle later.
    task automatic test_single_build();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A);
        tick();                                   // edge N: accepted
        drive_task(1'b0, 1'b0, '0);
        n_checks++; if (bus.pb0_start !== 1'b0)
            begin n_fail++; $display("FAIL single_early_start: got %b want 0", bus.pb0_start); end
        tick();                                   // edge N+1
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.pp_start} !== 3'b100)
            begin n_fail++; $display("FAIL single_start: got %b want 100", {bus.pb0_start, bus.pb1_start, bus.pp_start}); end
        n_checks++; if (bus.pb0_cfg !== CFG_A)
            begin n_fail++; $display("FAIL single_cfg: got %h want %h", bus.pb0_cfg, CFG_A); end
        tick();                                   // edge N+2
        n_checks++; if (bus.pb0_start !== 1'b0)
            begin n_fail++; $display("FAIL single_start_pulse: got %b want 0", bus.pb0_start); end
        tick(); tick(); tick();                   // edges N+3..N+5
        drive_irq(1'b1, 1'b0, 1'b0);
        tick();                                   // edge N+6: irq sampled
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.done_valid, bus.done_eng, bus.cont_busy} !== 4'b1_00_1)
            begin n_fail++; $display("FAIL single_done: got %b want 1001", {bus.done_valid, bus.done_eng, bus.cont_busy}); end
        n_checks++; if (bus.pb0_cfg !== CFG_A)
            begin n_fail++; $display("FAIL single_cfg_hold: got %h want %h", bus.pb0_cfg, CFG_A); end
        tick();                                   // edge N+7
        n_checks++; if ({bus.done_valid, bus.cont_busy} !== 2'b00)
            begin n_fail++; $display("FAIL single_idle: got %b want 00", {bus.done_valid, bus.cont_busy}); end
    endtask

    // Back-to-back builds alternate; third waits for the first irq.
    task automatic test_back_to_back();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A);
        tick();                                   // E0: accept A
        drive_task(1'b1, 1'b0, CFG_B);
        tick();                                   // E1: accept B, A->pb0
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.pb0_cfg} !== {2'b10, CFG_A})
            begin n_fail++; $display("FAIL b2b_first: got %b/%h want 10/%h", {bus.pb0_start, bus.pb1_start}, bus.pb0_cfg, CFG_A); end
        drive_task(1'b1, 1'b0, CFG_C);
        tick();                                   // E2: accept C, B->pb1
        drive_task(1'b0, 1'b0, '0);
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.pb1_cfg} !== {2'b01, CFG_B})
            begin n_fail++; $display("FAIL b2b_second: got %b/%h want 01/%h", {bus.pb0_start, bus.pb1_start}, bus.pb1_cfg, CFG_B); end
        tick(); tick();                           // E3, E4: C blocked
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.task_ready} !== 3'b001)
            begin n_fail++; $display("FAIL b2b_blocked: got %b want 001", {bus.pb0_start, bus.pb1_start, bus.task_ready}); end
        drive_irq(1'b1, 1'b0, 1'b0);
        tick();                                   // E5: pb0 irq
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.pb0_start, bus.done_valid, bus.done_eng} !== 4'b0_1_00)
            begin n_fail++; $display("FAIL b2b_done: got %b want 0100", {bus.pb0_start, bus.done_valid, bus.done_eng}); end
        tick();                                   // E6: C->pb0
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.pb0_cfg, bus.pb1_cfg} !== {2'b10, CFG_C, CFG_B})
            begin n_fail++; $display("FAIL b2b_third: got %b/%h/%h want 10/%h/%h", {bus.pb0_start, bus.pb1_start}, bus.pb0_cfg, bus.pb1_cfg, CFG_C, CFG_B); end
    endtask

    // A parse task behind a blocked build must wait for that build.
    task automatic test_order();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A); tick();    // E0
        drive_task(1'b1, 1'b0, CFG_B); tick();    // E1: A->pb0
        drive_task(1'b1, 1'b0, CFG_C); tick();    // E2: B->pb1
        drive_task(1'b1, 1'b1, CFG_D); tick();    // E3: accept parse, C blocked
        drive_task(1'b0, 1'b0, '0);
        n_checks++; if (bus.pp_start !== 1'b0)
            begin n_fail++; $display("FAIL order_pp_early0: got %b want 0", bus.pp_start); end
        tick(); tick();                           // E4, E5
        n_checks++; if ({bus.pp_start, bus.cont_busy} !== 2'b01)
            begin n_fail++; $display("FAIL order_pp_early1: got %b want 01", {bus.pp_start, bus.cont_busy}); end
        drive_irq(1'b0, 1'b1, 1'b0);
        tick();                                   // E6: pb1 idle
        drive_irq(1'b0, 1'b0, 1'b0);
        tick();                                   // E7: C->pb1
        n_checks++; if ({bus.pb1_start, bus.pp_start, bus.pb1_cfg} !== {2'b10, CFG_C})
            begin n_fail++; $display("FAIL order_build3: got %b/%h want 10/%h", {bus.pb1_start, bus.pp_start}, bus.pb1_cfg, CFG_C); end
        tick();                                   // E8: parse->pp
        n_checks++; if ({bus.pp_start, bus.pp_cfg} !== {1'b1, CFG_D})
            begin n_fail++; $display("FAIL order_parse: got %b/%h want 1/%h", bus.pp_start, bus.pp_cfg, CFG_D); end
    endtask

    // Full FIFO, ignored offer, ready after pop, simultaneous push/pop.
    task automatic test_full();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A); tick();    // E0
        drive_task(1'b1, 1'b0, CFG_B); tick();    // E1: A->pb0
        drive_task(1'b1, 1'b1, CFG_C); tick();    // E2: B->pb1
        drive_task(1'b1, 1'b0, CFG_D); tick();    // E3: parse->pp, D queued
        drive_task(1'b1, 1'b0, CFG_E); tick();    // E4
        drive_task(1'b1, 1'b0, CFG_F); tick();    // E5
        drive_task(1'b1, 1'b0, CFG_G); tick();    // E6: count = 4
        n_checks++; if (bus.task_ready !== 1'b0)
            begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.task_ready); end
        drive_task(1'b1, 1'b0, CFG_H);            // 5th offer, held
        tick();                                   // E7: ignored
        n_checks++; if ({bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start} !== 4'b0000)
            begin n_fail++; $display("FAIL full_ignore: got %b want 0000", {bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start}); end
        drive_irq(1'b1, 1'b0, 1'b0);
        tick();                                   // E8: pb0 idle
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.task_ready !== 1'b0)
            begin n_fail++; $display("FAIL full_ready_before_pop: got %b want 0", bus.task_ready); end
        tick();                                   // E9: D->pb0, count 3
        n_checks++; if ({bus.task_ready, bus.pb0_start, bus.pb0_cfg} !== {2'b11, CFG_D})
            begin n_fail++; $display("FAIL full_pop: got %b/%h want 11/%h", {bus.task_ready, bus.pb0_start}, bus.pb0_cfg, CFG_D); end
        tick();                                   // E10: H accepted, count 4
        drive_task(1'b0, 1'b0, '0);
        n_checks++; if (bus.task_ready !== 1'b0)
            begin n_fail++; $display("FAIL full_refill: got %b want 0", bus.task_ready); end
        drive_irq(1'b0, 1'b1, 1'b0);
        tick();                                   // E11: pb1 idle
        drive_irq(1'b1, 1'b0, 1'b0);
        tick();                                   // E12: E->pb1, pb0 idle, count 3
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.task_ready, bus.pb1_start, bus.pb1_cfg} !== {2'b11, CFG_E})
            begin n_fail++; $display("FAIL full_pop2: got %b/%h want 11/%h", {bus.task_ready, bus.pb1_start}, bus.pb1_cfg, CFG_E); end
        drive_task(1'b1, 1'b0, CFG_A);
        tick();                                   // E13: push A + F->pb0, count stays 3
        n_checks++; if ({bus.task_ready, bus.pb0_start, bus.pb0_cfg} !== {2'b11, CFG_F})
            begin n_fail++; $display("FAIL full_push_pop: got %b/%h want 11/%h", {bus.task_ready, bus.pb0_start}, bus.pb0_cfg, CFG_F); end
        drive_task(1'b1, 1'b0, CFG_B);
        tick();                                   // E14: push B, count 4
        drive_task(1'b0, 1'b0, '0);
        n_checks++; if (bus.task_ready !== 1'b0)
            begin n_fail++; $display("FAIL full_count_kept: got %b want 0", bus.task_ready); end
    endtask

    // Three irqs in one cycle are reported over three cycles; spurious irq
    // sets the sticky error flag.
    task automatic test_simultaneous_irq();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A); tick();    // E0
        drive_task(1'b1, 1'b0, CFG_B); tick();    // E1
        drive_task(1'b1, 1'b1, CFG_C); tick();    // E2
        drive_task(1'b0, 1'b0, '0);
        tick(); tick();                           // E3, E4: all WAIT
        drive_irq(1'b1, 1'b1, 1'b1);
        tick();                                   // E5
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.done_valid, bus.done_eng, bus.err_irq} !== 4'b1_00_0)
            begin n_fail++; $display("FAIL irq3_first: got %b want 1000", {bus.done_valid, bus.done_eng, bus.err_irq}); end
        tick();                                   // E6
        n_checks++; if ({bus.done_valid, bus.done_eng, bus.cont_busy} !== 4'b1_01_1)
            begin n_fail++; $display("FAIL irq3_second: got %b want 1011", {bus.done_valid, bus.done_eng, bus.cont_busy}); end
        tick();                                   // E7
        n_checks++; if ({bus.done_valid, bus.done_eng} !== 3'b1_10)
            begin n_fail++; $display("FAIL irq3_third: got %b want 110", {bus.done_valid, bus.done_eng}); end
        tick();                                   // E8
        n_checks++; if ({bus.done_valid, bus.cont_busy} !== 2'b00)
            begin n_fail++; $display("FAIL irq3_drained: got %b want 00", {bus.done_valid, bus.cont_busy}); end
        drive_irq(1'b0, 1'b0, 1'b1);
        tick();                                   // E9: spurious pp irq
        drive_irq(1'b0, 1'b0, 1'b0);
        n_checks++; if ({bus.err_irq, bus.done_valid} !== 2'b10)
            begin n_fail++; $display("FAIL spurious_err: got %b want 10", {bus.err_irq, bus.done_valid}); end
        tick(); tick();
        n_checks++; if ({bus.err_irq, bus.done_valid, bus.cont_busy} !== 3'b100)
            begin n_fail++; $display("FAIL spurious_sticky: got %b want 100", {bus.err_irq, bus.done_valid, bus.cont_busy}); end
    endtask

    // Reset mid-operation drops queued tasks; next task goes to pb0.
    task automatic test_reset_mid_op();
        do_reset();
        drive_task(1'b1, 1'b0, CFG_A); tick();    // E0
        drive_task(1'b1, 1'b0, CFG_B); tick();    // E1: A->pb0
        drive_task(1'b1, 1'b0, CFG_C); tick();    // E2: B->pb1
        drive_task(1'b1, 1'b0, CFG_D); tick();    // E3: C, D queued
        drive_task(1'b0, 1'b0, '0);
        tick();                                   // E4
        reset = 1'b0;
        #2;
        n_checks++; if ({bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start, bus.done_valid, bus.done_eng, bus.cont_busy, bus.err_irq} !== 9'b0)
            begin n_fail++; $display("FAIL midrst_flags: got %b want 0", {bus.task_ready, bus.pb0_start, bus.pb1_start, bus.pp_start, bus.done_valid, bus.done_eng, bus.cont_busy, bus.err_irq}); end
        n_checks++; if ({bus.pb0_cfg, bus.pb1_cfg, bus.pp_cfg} !== '0)
            begin n_fail++; $display("FAIL midrst_cfg: got %h want 0", {bus.pb0_cfg, bus.pb1_cfg, bus.pp_cfg}); end
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        n_checks++; if ({bus.task_ready, bus.cont_busy, bus.pb0_start, bus.pb1_start} !== 4'b1000)
            begin n_fail++; $display("FAIL midrst_empty: got %b want 1000", {bus.task_ready, bus.cont_busy, bus.pb0_start, bus.pb1_start}); end
        drive_task(1'b1, 1'b0, CFG_E);
        tick();
        drive_task(1'b0, 1'b0, '0);
        tick();
        n_checks++; if ({bus.pb0_start, bus.pb1_start, bus.pb0_cfg} !== {2'b10, CFG_E})
            begin n_fail++; $display("FAIL midrst_new_task: got %b/%h want 10/%h", {bus.pb0_start, bus.pb1_start}, bus.pb0_cfg, CFG_E); end
    endtask

    initial begin
        test_reset();
        test_single_build();
        test_back_to_back();
        test_order();
        test_full();
        test_simultaneous_irq();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
